mac_seq_ctrl: RTL

//  Job sequencer for the precision-scalable MAC unit. Accepts one dot-product job
//  (length, precision level), clears the MAC, and streams act/weight pairs into it.
//  It drains the MAC's 2-stage pipeline and returns the 56-bit accumulated result.
//  The block sits between the operand buffer/DMA and one MAC unit instance.

---
 rtl/mac_seq_ctrl_if.sv | 31 +++
 rtl/mac_seq_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl_if.sv
// mac_seq_ctrl_if: job, operand and result handshakes between the sequencer and its host side
//   cfg_*  : job request (valid/ready, beat count, precision level)
//   op_*   : activation/weight operand stream (valid/ready)
//   res_*  : accumulated result return (valid/ready, data, precision)
// slave  : used by the sequencer
// master : used by the host (operand buffer / DMA / result sink)
interface mac_seq_ctrl_if #(
   parameter int LEN_W = 16,
   parameter int ACC_W = 56
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [LEN_W-1:0] cfg_len;
   logic [1:0]       cfg_prec;
   logic             op_valid;
   logic             op_ready;
   logic [7:0]       op_act;
   logic [7:0]       op_wgt;
   logic             res_valid;
   logic             res_ready;
   logic [ACC_W-1:0] res_data;
   logic [1:0]       res_prec;
   modport master (
      output cfg_valid, cfg_len, cfg_prec, op_valid, op_act, op_wgt, res_ready,
      input  cfg_ready, op_ready, res_valid, res_data, res_prec
   );
   modport slave (
      input  cfg_valid, cfg_len, cfg_prec, op_valid, op_act, op_wgt, res_ready,
      output cfg_ready, op_ready, res_valid, res_data, res_prec
   );
endinterface

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: job sequencer for the precision-scalable MAC unit
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : cfg / op / res handshakes
//   mac_act_o/wgt_o : operands to the MAC (zero outside RUN and during drain)
//   mac_prec_o      : latched precision level
//   mac_en_o        : MAC enable
//   mac_clr_o       : registered clear pulse (MAC reset = rst_n & ~mac_clr_o)
//   mac_result_i    : MAC accumulator
//   busy_o          : sequencer not idle
//   err_o           : one-cycle pulse when an illegal precision request is rejected
//   perf_stalls_o   : RUN cycles without operand in the current/last job (saturating)
module mac_seq_ctrl #(
   parameter int LEN_W   = 16,
   parameter int ACC_W   = 56,
   parameter int DRAIN_C = 2,
   parameter int PERF_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   mac_seq_ctrl_if.slave     bus,
   output logic [7:0]        mac_act_o,
   output logic [7:0]        mac_wgt_o,
   output logic [1:0]        mac_prec_o,
   output logic              mac_en_o,
   output logic              mac_clr_o,
   input  logic [ACC_W-1:0]  mac_result_i,
   output logic              busy_o,
   output logic              err_o,
   output logic [PERF_W-1:0] perf_stalls_o
);
   typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;
   state_t state_q, state_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        prec_q, prec_d;
   logic [PERF_W-1:0] perf_q, perf_d;
   logic              err_q, err_d;
   logic              clr_q, clr_d;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         prec_q  <= '0;
         perf_q  <= '0;
         err_q   <= 1'b0;
         clr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prec_q  <= prec_d;
         perf_q  <= perf_d;
         err_q   <= err_d;
         clr_q   <= clr_d;
      end
   end
   // cnt_q counts remaining beats in RUN, then is reused as the drain countdown
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prec_d  = prec_q;
      perf_d  = perf_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE:
            if (bus.cfg_valid) begin
               if (bus.cfg_prec == 2'b11) err_d = 1'b1;
               else begin
                  prec_d  = bus.cfg_prec;
                  cnt_d   = bus.cfg_len;
                  perf_d  = '0;
                  state_d = CLEAR;
               end
            end
         CLEAR: begin
            state_d = (cnt_q == '0) ? DRAIN : RUN;
            cnt_d   = (cnt_q == '0) ? LEN_W'(DRAIN_C - 1) : cnt_q;
         end
         RUN:
            if (bus.op_valid) begin
               state_d = (cnt_q == LEN_W'(1)) ? DRAIN : RUN;
               cnt_d   = (cnt_q == LEN_W'(1)) ? LEN_W'(DRAIN_C - 1) : cnt_q - LEN_W'(1);
            end else perf_d = perf_q + PERF_W'(perf_q != '1);
         DRAIN: begin
            state_d = (cnt_q == '0) ? DONE : DRAIN;
            cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - LEN_W'(1);
         end
         DONE:
            if (bus.res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      clr_d = (state_d == CLEAR);
   end
   always_comb begin
      bus.cfg_ready = (state_q == IDLE);
      bus.op_ready  = (state_q == RUN);
      bus.res_valid = (state_q == DONE);
      bus.res_data  = (state_q == DONE) ? mac_result_i : '0;
      bus.res_prec  = prec_q;
      mac_act_o     = (state_q == RUN) ? bus.op_act : 8'd0;
      mac_wgt_o     = (state_q == RUN) ? bus.op_wgt : 8'd0;
      mac_en_o      = (state_q == RUN) ? bus.op_valid : (state_q == DRAIN);
      mac_prec_o    = prec_q;
      mac_clr_o     = clr_q;
      busy_o        = (state_q != IDLE);
      err_o         = err_q;
      perf_stalls_o = perf_q;
   end
endmodule
